// File: rtl/instr_stream_loader.sv
// instr_stream_loader: packs a byte-serial WebAssembly stream into write
// windows of up to WINDOW bytes for the instruction memory controller.
// Each window is issued as one `we` pulse with the byte count minus one
// on write_pointer_shift_minusone.
// Optional feature: define INSTR_LOADER_MAGIC_CHECK_EN to check the first
// four bytes of each load against the "\0asm" magic (00 61 73 6d).
module instr_stream_loader #(
   parameter int unsigned WINDOW     = 4,
   parameter int unsigned LOG_WINDOW = 2,
   parameter int unsigned MAX_BYTES  = 256,
   parameter int unsigned CNT_W      = 9,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [7:0]              s_data,
   input  logic                    s_valid,
   input  logic                    s_last,
   output logic                    s_ready,
   input  logic                    stall,
   output logic                    we,
   output logic [LOG_WINDOW-1:0]   write_pointer_shift_minusone,
   output logic [WINDOW*8-1:0]     wr_data,
   output logic                    load_done,
   output logic [CNT_W-1:0]        byte_count,
   output logic                    cap_err,
   output logic                    magic_err
);

   localparam int unsigned IW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [LOG_WINDOW:0] WIN_C    = (LOG_WINDOW+1)'(WINDOW);
   localparam logic [CNT_W-1:0]    MAX_C    = CNT_W'(MAX_BYTES);
   localparam logic [IW-1:0]       IDLE_LIM = IW'(TIMEOUT - 2);

   typedef enum logic [1:0] {IDLE, FILL, EMIT, DONE} state_t;

   state_t               state, state_nx;
   logic [LOG_WINDOW:0]  fill_cnt, fill_inc;
   logic [CNT_W-1:0]     count_inc;
   logic [IW-1:0]        idle_cnt;
   logic [WINDOW*8-1:0]  lanes;
   logic                 last_seen;
   logic                 hs, cap_hit, win_done, idle_flush, magic_bad;

   assign hs        = s_valid && (state == FILL);
   assign fill_inc  = fill_cnt + 1'b1;
   assign count_inc = byte_count + 1'b1;
   assign cap_hit   = hs && !s_last && (count_inc == MAX_C);
   assign win_done  = hs && ((fill_inc == WIN_C) || s_last || cap_hit);
   // idle_cnt reaches TIMEOUT-1 on this edge, so the flush is taken here
   assign idle_flush = (state == FILL) && !hs && (fill_cnt != '0) && (idle_cnt == IDLE_LIM);

`ifdef INSTR_LOADER_MAGIC_CHECK_EN
   logic [7:0] magic_byte;

   // expected magic byte for the current position in the load
   always_comb begin
      magic_byte = 8'h00;
      case (byte_count[1:0])
         2'd0:    magic_byte = 8'h00;
         2'd1:    magic_byte = 8'h61;
         2'd2:    magic_byte = 8'h73;
         default: magic_byte = 8'h6d;
      endcase
   end

   assign magic_bad = hs && (byte_count < CNT_W'(4)) && (s_data != magic_byte);
`else
   assign magic_bad = 1'b0;
`endif

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // next-state and handshake/strobe outputs
   always_comb begin
      state_nx  = state;
      s_ready   = 1'b0;
      we        = 1'b0;
      load_done = 1'b0;
      write_pointer_shift_minusone = '0;
      case (state)
         IDLE: begin
            if (start) state_nx = FILL;
         end
         FILL: begin
            s_ready = 1'b1;
            if (magic_bad)                  state_nx = DONE;
            else if (win_done || idle_flush) state_nx = EMIT;
         end
         EMIT: begin
            we = !stall;
            write_pointer_shift_minusone = fill_cnt[LOG_WINDOW-1:0] - 1'b1;
            if (!stall) state_nx = last_seen ? DONE : FILL;
         end
         DONE: begin
            load_done = 1'b1;
            if (start) state_nx = FILL;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign wr_data = lanes;

   // window lanes, counters and sticky error flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_cnt   <= '0;
         byte_count <= '0;
         idle_cnt   <= '0;
         lanes      <= '0;
         last_seen  <= 1'b0;
         cap_err    <= 1'b0;
         magic_err  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  fill_cnt   <= '0;
                  byte_count <= '0;
                  idle_cnt   <= '0;
                  lanes      <= '0;
                  last_seen  <= 1'b0;
                  cap_err    <= 1'b0;
                  magic_err  <= 1'b0;
               end
            end
            FILL: begin
               if (magic_bad) begin
                  magic_err <= 1'b1;
                  fill_cnt  <= '0;
                  lanes     <= '0;
                  idle_cnt  <= '0;
               end else if (hs) begin
                  for (int unsigned j = 0; j < WINDOW; j++) begin
                     if (fill_cnt == (LOG_WINDOW+1)'(j)) lanes[j*8 +: 8] <= s_data;
                  end
                  fill_cnt <= fill_inc;
                  if (byte_count < MAX_C) byte_count <= count_inc;
                  idle_cnt <= '0;
                  if (s_last || cap_hit) last_seen <= 1'b1;
                  if (cap_hit)           cap_err   <= 1'b1;
               end else if (fill_cnt != '0) begin
                  idle_cnt <= idle_flush ? '0 : idle_cnt + 1'b1;
               end
            end
            EMIT: begin
               if (!stall) begin
                  fill_cnt <= '0;
                  lanes    <= '0;
                  idle_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_stream_loader.sv
// tb_instr_stream_loader: directed table-driven bench for instr_stream_loader.
// A second instance with MAX_BYTES=8 exercises the capacity stop.
// Honours INSTR_LOADER_MAGIC_CHECK_EN for the magic-byte sequence.
module tb_instr_stream_loader;

   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic        s_valid = 1'b0, s_last = 1'b0, stall = 1'b0;
   logic [7:0]  s_data = '0;

   logic        s_ready, we, load_done, cap_err, magic_err;
   logic [1:0]  shift;
   logic [31:0] wr_data;
   logic [8:0]  byte_count;

   logic        s_ready2, we2, load_done2, cap_err2, magic_err2;
   logic [1:0]  shift2;
   logic [31:0] wr_data2;
   logic [3:0]  byte_count2;

   int checks = 0;
   int errors = 0;
   int we_cnt = 0;

   instr_stream_loader #(.WINDOW(4), .LOG_WINDOW(2), .MAX_BYTES(256), .CNT_W(9), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .s_data(s_data), .s_valid(s_valid),
      .s_last(s_last), .s_ready(s_ready), .stall(stall), .we(we),
      .write_pointer_shift_minusone(shift), .wr_data(wr_data), .load_done(load_done),
      .byte_count(byte_count), .cap_err(cap_err), .magic_err(magic_err));

   instr_stream_loader #(.WINDOW(4), .LOG_WINDOW(2), .MAX_BYTES(8), .CNT_W(4), .TIMEOUT(16)) dut_cap (
      .clk(clk), .rst_n(rst_n), .start(start), .s_data(s_data), .s_valid(s_valid),
      .s_last(s_last), .s_ready(s_ready2), .stall(stall), .we(we2),
      .write_pointer_shift_minusone(shift2), .wr_data(wr_data2), .load_done(load_done2),
      .byte_count(byte_count2), .cap_err(cap_err2), .magic_err(magic_err2));

   always #5 clk = ~clk;

   // count write strobes of the main instance
   always @(posedge clk) if (we) we_cnt++;

   // hard stop if the flow ever wedges
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   typedef struct {
      bit          start;
      int          n;
      logic [31:0] bytes;
      bit          last;
      logic [1:0]  shift;
      logic [31:0] wd;
      bit          done;
      int          cnt;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic l);
      int n;
      @(negedge clk);
      s_data = d; s_valid = 1'b1; s_last = l;
      n = 0;
      while (!s_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) chk("send_ready", {63'b0, s_ready}, 64'd1);
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic wait_we(output int k);
      k = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (we) begin
            k = i;
            break;
         end
      end
   endtask

   initial begin
      int          k, wc0, idx, pulses;
      logic        r;
      logic [31:0] wq[2];
      logic [1:0]  sq[2];
      logic [7:0]  arr[10];
      logic [31:0] bv;

      tbl[0] = '{1'b1, 4, 32'h6d736100, 1'b0, 2'd3, 32'h6d736100, 1'b0, 4};
      tbl[1] = '{1'b0, 4, 32'h00000001, 1'b1, 2'd3, 32'h00000001, 1'b1, 8};
      tbl[2] = '{1'b1, 4, 32'h6d736100, 1'b0, 2'd3, 32'h6d736100, 1'b0, 4};
      tbl[3] = '{1'b0, 2, 32'h00000201, 1'b1, 2'd1, 32'h00000201, 1'b1, 6};
      tbl[4] = '{1'b1, 4, 32'h6d736100, 1'b0, 2'd3, 32'h6d736100, 1'b0, 4};
      tbl[5] = '{1'b0, 1, 32'h00000005, 1'b1, 2'd0, 32'h00000005, 1'b1, 5};

      // reset values
      repeat (2) @(negedge clk);
      chk("rst_we", {63'b0, we}, 64'd0);
      chk("rst_s_ready", {63'b0, s_ready}, 64'd0);
      chk("rst_wr_data", {32'b0, wr_data}, 64'd0);
      chk("rst_shift", {62'b0, shift}, 64'd0);
      chk("rst_load_done", {63'b0, load_done}, 64'd0);
      chk("rst_byte_count", {55'b0, byte_count}, 64'd0);
      chk("rst_errs", {62'b0, cap_err, magic_err}, 64'd0);
      @(negedge clk); rst_n = 1'b1;

      // table-driven windows
      for (int row = 0; row < 6; row++) begin
         if (tbl[row].start) pulse_start();
         bv = tbl[row].bytes;
         for (int j = 0; j < tbl[row].n; j++)
            send_byte(bv[j*8 +: 8], tbl[row].last && (j == tbl[row].n - 1));
         wait_we(k);
         chk($sformatf("row%0d_latency", row), 64'(k), 64'd0);
         chk($sformatf("row%0d_shift", row), {62'b0, shift}, {62'b0, tbl[row].shift});
         chk($sformatf("row%0d_wr_data", row), {32'b0, wr_data}, {32'b0, tbl[row].wd});
         @(posedge clk); #1;
         @(negedge clk);
         chk($sformatf("row%0d_we_drop", row), {63'b0, we}, 64'd0);
         chk($sformatf("row%0d_load_done", row), {63'b0, load_done}, {63'b0, tbl[row].done});
         chk($sformatf("row%0d_byte_count", row), {55'b0, byte_count}, 64'(tbl[row].cnt));
         chk($sformatf("row%0d_s_ready", row), {63'b0, s_ready}, {63'b0, !tbl[row].done});
      end

      // idle flush of a two-byte partial window
      pulse_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h61, 1'b0);
      wait_we(k);
      chk("flush_idle_cycle", 64'(k), 64'd15);
      chk("flush_shift", {62'b0, shift}, 64'd1);
      chk("flush_wr_data", {32'b0, wr_data}, 64'h00006100);
      @(posedge clk); #1;
      @(negedge clk);
      chk("flush_load_done", {63'b0, load_done}, 64'd0);
      chk("flush_s_ready", {63'b0, s_ready}, 64'd1);
      chk("flush_byte_count", {55'b0, byte_count}, 64'd2);

      // stall holds a full window in EMIT
      send_byte(8'h73, 1'b0);
      send_byte(8'h6d, 1'b0);
      send_byte(8'h01, 1'b0);
      stall = 1'b1;
      send_byte(8'h02, 1'b0);
      wc0 = we_cnt;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("stall%0d_we", c), {63'b0, we}, 64'd0);
         chk($sformatf("stall%0d_s_ready", c), {63'b0, s_ready}, 64'd0);
         chk($sformatf("stall%0d_wr_data", c), {32'b0, wr_data}, 64'h02016d73);
      end
      @(negedge clk); stall = 1'b0;
      #1;
      chk("stall_release_we", {63'b0, we}, 64'd1);
      chk("stall_release_wr_data", {32'b0, wr_data}, 64'h02016d73);
      chk("stall_release_shift", {62'b0, shift}, 64'd3);
      @(posedge clk); #1;
      @(negedge clk);
      chk("stall_we_single", {63'b0, we}, 64'd0);
      chk("stall_we_count", 64'(we_cnt - wc0), 64'd1);
      chk("stall_back_to_fill", {63'b0, s_ready}, 64'd1);
      chk("stall_byte_count", {55'b0, byte_count}, 64'd6);

      // reset with a partial window discards it
      send_byte(8'h03, 1'b0);
      wc0 = we_cnt;
      @(negedge clk); rst_n = 1'b0;
      #1;
      chk("midrst_wr_data", {32'b0, wr_data}, 64'd0);
      chk("midrst_byte_count", {55'b0, byte_count}, 64'd0);
      chk("midrst_s_ready", {63'b0, s_ready}, 64'd0);
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("midrst_no_we", 64'(we_cnt - wc0), 64'd0);
      chk("midrst_idle", {62'b0, s_ready, load_done}, 64'd0);

      // capacity stop on the MAX_BYTES=8 instance
      arr = '{8'h00, 8'h61, 8'h73, 8'h6d, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      pulse_start();
      idx = 0;
      pulses = 0;
      wq = '{32'h0, 32'h0};
      sq = '{2'd0, 2'd0};
      for (int c = 0; c < 60 && !load_done2; c++) begin
         @(negedge clk);
         if (we2) begin
            if (pulses < 2) begin
               wq[pulses] = wr_data2;
               sq[pulses] = shift2;
            end
            pulses++;
         end
         s_data  = arr[(idx < 10) ? idx : 9];
         s_valid = (idx < 10);
         r = s_ready2 && s_valid;
         @(posedge clk); #1;
         if (r) idx++;
      end
      @(negedge clk);
      chk("cap_ninth_not_ready", {63'b0, s_ready2}, 64'd0);
      s_valid = 1'b0;
      chk("cap_accepted", 64'(idx), 64'd8);
      chk("cap_pulses", 64'(pulses), 64'd2);
      chk("cap_win0", {32'b0, wq[0]}, 64'h6d736100);
      chk("cap_win1", {32'b0, wq[1]}, 64'h04030201);
      chk("cap_shifts", {60'b0, sq[0], sq[1]}, 64'hf);
      chk("cap_err", {63'b0, cap_err2}, 64'd1);
      chk("cap_done", {63'b0, load_done2}, 64'd1);
      chk("cap_byte_count", {60'b0, byte_count2}, 64'd8);

      // magic check
      do_reset();
      pulse_start();
      wc0 = we_cnt;
      send_byte(8'h00, 1'b0);
      send_byte(8'h61, 1'b0);
      send_byte(8'h74, 1'b0);
      @(negedge clk);
`ifdef INSTR_LOADER_MAGIC_CHECK_EN
      chk("magic_err", {63'b0, magic_err}, 64'd1);
      chk("magic_done", {63'b0, load_done}, 64'd1);
      chk("magic_no_we", 64'(we_cnt - wc0), 64'd0);
      pulse_start();
      @(negedge clk);
      chk("magic_restart_err", {63'b0, magic_err}, 64'd0);
      chk("magic_restart_ready", {63'b0, s_ready}, 64'd1);
      chk("magic_restart_done", {63'b0, load_done}, 64'd0);
`else
      chk("nomagic_err", {63'b0, magic_err}, 64'd0);
      chk("nomagic_done", {63'b0, load_done}, 64'd0);
      chk("nomagic_ready", {63'b0, s_ready}, 64'd1);
      chk("nomagic_count", {55'b0, byte_count}, 64'd3);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_stream_loader.md
# instr_stream_loader

Write-side feeder for the instruction memory controller. Accepts a byte-serial WebAssembly binary stream over a valid/ready handshake and packs the bytes into write windows of up to WINDOW bytes. Each window is issued to the controller's write port as one `we` pulse, with `write_pointer_shift_minusone` set to the byte count minus one. The block sits between the host/boot interface and the instruction memory controller.

## Interface
- WINDOW, 4, bytes per write window; must equal the controller's write window size
- LOG_WINDOW, 2, width of shift field; 2^LOG_WINDOW ≥ WINDOW
- MAX_BYTES, 256, bytes accepted per load before capacity stop
- CNT_W, 9, width of byte_count; 2^CNT_W > MAX_BYTES
- TIMEOUT, 16, idle cycles before a partial window is flushed

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle pulse; arms a new load from IDLE or DONE
- s_data  in  8  stream byte
- s_valid  in  1  byte valid
- s_last  in  1  qualifies the final byte of the binary
- s_ready  out  1  byte accepted on an edge where s_valid & s_ready
- stall  in  1  write-port hold (core busy); blocks `we`
- we  out  1  write strobe, one cycle per window
- write_pointer_shift_minusone  out  LOG_WINDOW  bytes in window minus one
- wr_data  out  WINDOW*8  byte j in bits [j*8 +: 8]; unused lanes are 0
- load_done  out  1  high in DONE
- byte_count  out  CNT_W  bytes accepted in current load
- cap_err  out  1  sticky; capacity reached before s_last
- magic_err  out  1  sticky; see Configuration

## Operation
- States: IDLE, FILL, EMIT, DONE. Reset state is IDLE.
- IDLE: s_ready=0. start → FILL and clear fill_cnt, byte_count, idle_cnt, cap_err, magic_err.
- FILL: s_ready=1. On each handshake:
  - write s_data to lane fill_cnt;
  - fill_cnt++ and byte_count++;
  - idle_cnt=0.
- FILL exits to EMIT on the handshake edge that completes any one of:
  - fill_cnt reaching WINDOW;
  - s_last accepted, which also sets last_seen;
  - byte_count reaching MAX_BYTES without s_last, which also sets cap_err and last_seen.
- FILL idle flush: when fill_cnt>0 and there is no handshake, idle_cnt++. When idle_cnt = TIMEOUT-1 → EMIT. When fill_cnt=0, idle_cnt holds at 0.
- EMIT: s_ready=0. `we` = ~stall (combinational from state). The shift field = fill_cnt-1 and wr_data come from registers and are stable for all of EMIT. On the edge where `we` is high:
  - fill_cnt=0 and the lanes are cleared;
  - → DONE if last_seen, else → FILL.
- DONE: load_done=1, s_ready=0. start → FILL with counters and error flags cleared. start in FILL or EMIT is ignored.
- Arithmetic: fill_cnt is LOG_WINDOW+1 bits. byte_count saturates at MAX_BYTES; it is never exceeded because s_ready is 0 outside FILL.
- Reset values: we=0, s_ready=0, wr_data=0, shift=0, load_done=0, byte_count=0, cap_err=0, magic_err=0.
- Reset mid-operation: the partial window is discarded and no `we` is issued.

## Timing
- Throughput: WINDOW handshake cycles plus at least one EMIT cycle per full window.
- Latency: the window-completing handshake at edge N gives `we` high in cycle N..N+1 when stall=0. Each cycle of stall delays `we` by one cycle.
- `we` is high for exactly one cycle per window, never back-to-back.
- s_last accepted with fill_cnt=1 emits shift=0.
- A stall that rises while in EMIT holds `we` low; wr_data holds.
- s_last on the byte that fills the window produces exactly one EMIT, then DONE.
- Timeout flush and a handshake in the same cycle: the handshake wins and idle_cnt resets.

## Configuration
- `INSTR_LOADER_MAGIC_CHECK_EN` defined: during the first four handshakes of a load, each byte is compared with 00 61 73 6d in order.
  - On the first mismatch, set magic_err and go to DONE at that edge.
  - The current partial window is dropped with no `we`; windows already emitted stand.
- Undefined: no check; magic_err is tied 0.

## Test plan
- Stream 00 61 73 6d 01 00 00 00 with s_last on the 8th byte, stall=0 → two `we` pulses with shift=3: wr_data=32'h6d736100, then 32'h00000001. Then load_done=1 and byte_count=8.
- Stream 6 bytes with s_last on the 6th → `we` with shift=3, then `we` with shift=1 and the upper two lanes zero; DONE.
- Send 2 bytes, then hold s_valid=0 for 16 cycles → `we` with shift=1 on the 16th idle cycle; back in FILL; load_done=0.
- Hold stall=1 for 5 cycles after a full window → `we` stays low for those 5 cycles and s_ready=0. Then a single `we` with unchanged wr_data.
- MAX_BYTES=8, stream 10 bytes with no s_last → two `we` pulses, cap_err=1, DONE. s_ready=0 for the 9th byte.
- With `INSTR_LOADER_MAGIC_CHECK_EN`, stream 00 61 74 → magic_err=1 and DONE with no `we`. A start pulse then clears magic_err and returns to FILL.
